// File: rtl/seg7_scan_display.sv
// rtl/seg7_scan_display.sv - eight-digit multiplexed hex seven-segment driver with input filter and halt marker
// Optional halt blink is compiled in with SEG_HALT_BLINK_EN.
module seg7_scan_display #(
   parameter int SCAN_DIV  = 100000,
   parameter int BLINK_DIV = 50000000
) (
   input  logic        clk,
   input  logic        CLR,
   input  logic [31:0] data,
   input  logic        halt,
   input  logic        blank_lz,
   output logic [7:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam int CW = $clog2(SCAN_DIV);

   logic [31:0]   data_q;
   logic [31:0]   shown;
   logic          halt_m;
   logic          halt_s;
   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic          blink_off;

   logic [3:0]    nib;
   logic [31:0]   upper;
   logic          lz_blank;
   logic [6:0]    seg_d;

   function automatic logic [6:0] hex7(input logic [3:0] h);
      case (h)
         4'h0: hex7 = 7'h40;
         4'h1: hex7 = 7'h79;
         4'h2: hex7 = 7'h24;
         4'h3: hex7 = 7'h30;
         4'h4: hex7 = 7'h19;
         4'h5: hex7 = 7'h12;
         4'h6: hex7 = 7'h02;
         4'h7: hex7 = 7'h78;
         4'h8: hex7 = 7'h00;
         4'h9: hex7 = 7'h10;
         4'hA: hex7 = 7'h08;
         4'hB: hex7 = 7'h03;
         4'hC: hex7 = 7'h46;
         4'hD: hex7 = 7'h21;
         4'hE: hex7 = 7'h06;
         default: hex7 = 7'h0E;
      endcase
   endfunction

   always_comb begin
      nib      = shown[{idx, 2'b00} +: 4];
      upper    = shown >> {idx, 2'b00};
      lz_blank = blank_lz && (idx != 3'd0) && (upper == 32'd0);
      seg_d    = hex7(nib);
   end

   // A word is accepted only after two identical consecutive samples.
   always_ff @(posedge clk or posedge CLR) begin
      if (CLR) begin
         data_q <= '0;
         shown  <= '0;
         halt_m <= 1'b0;
         halt_s <= 1'b0;
      end else begin
         data_q <= data;
         if (data == data_q)
            shown <= data;
         halt_m <= halt;
         halt_s <= halt_m;
      end
   end

   always_ff @(posedge clk or posedge CLR) begin
      if (CLR) begin
         cnt <= '0;
         idx <= 3'd0;
      end else if (cnt == CW'(SCAN_DIV - 1)) begin
         cnt <= '0;
         idx <= idx + 3'd1;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

`ifdef SEG_HALT_BLINK_EN
   localparam int BW = $clog2(BLINK_DIV + 1);
   logic [BW-1:0] bcnt;

   always_ff @(posedge clk or posedge CLR) begin
      if (CLR) begin
         bcnt      <= '0;
         blink_off <= 1'b0;
      end else if (!halt_s) begin
         bcnt      <= '0;
         blink_off <= 1'b0;
      end else if (bcnt == BW'(BLINK_DIV - 1)) begin
         bcnt      <= '0;
         blink_off <= ~blink_off;
      end else begin
         bcnt <= bcnt + BW'(1);
      end
   end
`else
   assign blink_off = 1'b0;
`endif

   // All three outputs register together so a digit change never ghosts.
   always_ff @(posedge clk or posedge CLR) begin
      if (CLR) begin
         an  <= 8'hFF;
         seg <= 7'h7F;
         dp  <= 1'b1;
      end else begin
         an  <= (lz_blank || blink_off) ? 8'hFF : ~(8'h01 << idx);
         seg <= seg_d;
         dp  <= (idx == 3'd0) ? ~halt_s : 1'b1;
      end
   end

endmodule

// File: tb/tb_seg7_scan_display.sv
// tb/tb_seg7_scan_display.sv - table-driven bench for seg7_scan_display (SCAN_DIV=4, BLINK_DIV=8)
module tb_seg7_scan_display;

   logic        clk;
   logic        CLR;
   logic [31:0] data;
   logic        halt;
   logic        blank_lz;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp;

   int n_tests;
   int n_fail;
   int edge_n;

   typedef struct {
      logic [31:0] data;
      logic        blz;
      int          digit;
      logic [7:0]  an;
      logic [6:0]  seg;
      logic        chk_seg;
   } vec_t;

   vec_t vecs[18];

   seg7_scan_display #(.SCAN_DIV(4), .BLINK_DIV(8)) dut (
      .clk      (clk),
      .CLR      (CLR),
      .data     (data),
      .halt     (halt),
      .blank_lz (blank_lz),
      .an       (an),
      .seg      (seg),
      .dp       (dp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edges since reset release; output slot = ((edge_n-1)/4)%8.
   always @(posedge clk or posedge CLR) begin
      if (CLR) edge_n <= 0;
      else     edge_n <= edge_n + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic goto_pos(input int d, input int p);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 80 && !found; i++) begin
         @(negedge clk);
         if (edge_n >= 1 && ((edge_n - 1) / 4) % 8 == d && (edge_n - 1) % 4 == p)
            found = 1'b1;
      end
      n_tests++;
      if (!found) begin
         n_fail++;
         $display("FAIL goto_pos: slot %0d pos %0d not reached, got edge %0d", d, p, edge_n);
      end
   endtask

   initial begin
      logic [7:0] exp_an;
      int         cnt_off;

      n_tests = 0;
      n_fail  = 0;

      vecs[0]  = '{32'hFEDCBA98, 1'b0, 0, 8'hFE, 7'h00, 1'b1};
      vecs[1]  = '{32'hFEDCBA98, 1'b0, 1, 8'hFD, 7'h10, 1'b1};
      vecs[2]  = '{32'hFEDCBA98, 1'b0, 2, 8'hFB, 7'h08, 1'b1};
      vecs[3]  = '{32'hFEDCBA98, 1'b0, 3, 8'hF7, 7'h03, 1'b1};
      vecs[4]  = '{32'hFEDCBA98, 1'b0, 4, 8'hEF, 7'h46, 1'b1};
      vecs[5]  = '{32'hFEDCBA98, 1'b0, 5, 8'hDF, 7'h21, 1'b1};
      vecs[6]  = '{32'hFEDCBA98, 1'b0, 6, 8'hBF, 7'h06, 1'b1};
      vecs[7]  = '{32'hFEDCBA98, 1'b0, 7, 8'h7F, 7'h0E, 1'b1};
      vecs[8]  = '{32'h000000A5, 1'b1, 0, 8'hFE, 7'h12, 1'b1};
      vecs[9]  = '{32'h000000A5, 1'b1, 1, 8'hFD, 7'h08, 1'b1};
      vecs[10] = '{32'h000000A5, 1'b1, 2, 8'hFF, 7'h00, 1'b0};
      vecs[11] = '{32'h000000A5, 1'b1, 5, 8'hFF, 7'h00, 1'b0};
      vecs[12] = '{32'h000000A5, 1'b1, 7, 8'hFF, 7'h00, 1'b0};
      vecs[13] = '{32'h00000000, 1'b1, 0, 8'hFE, 7'h40, 1'b1};
      vecs[14] = '{32'h00000000, 1'b1, 1, 8'hFF, 7'h00, 1'b0};
      vecs[15] = '{32'h00000000, 1'b1, 7, 8'hFF, 7'h00, 1'b0};
      vecs[16] = '{32'h000000A5, 1'b0, 2, 8'hFB, 7'h40, 1'b1};
      vecs[17] = '{32'h00000000, 1'b0, 4, 8'hEF, 7'h40, 1'b1};

      // Reset and first scan
      CLR      = 1'b1;
      data     = 32'h12345678;
      halt     = 1'b0;
      blank_lz = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_an", {24'd0, an}, 32'hFF);
      check("rst_seg", {25'd0, seg}, 32'h7F);
      check("rst_dp", {31'd0, dp}, 32'h1);
      CLR = 1'b0;
      @(negedge clk);
      check("first_an", {24'd0, an}, 32'hFE);
      repeat (2) @(negedge clk);
      check("first_seg8", {25'd0, seg}, 32'h00);
      for (int k = 1; k <= 8; k++) begin
         goto_pos(k % 8, 0);
         exp_an = ~(8'h01 << (k % 8));
         check("scan_an", {24'd0, an}, {24'd0, exp_an});
      end

      // Table-driven digit/blanking vectors
      for (int v = 0; v < 18; v++) begin
         data     = vecs[v].data;
         blank_lz = vecs[v].blz;
         repeat (4) @(negedge clk);
         goto_pos(vecs[v].digit, 2);
         check($sformatf("vec%0d_an", v), {24'd0, an}, {24'd0, vecs[v].an});
         if (vecs[v].chk_seg)
            check($sformatf("vec%0d_seg", v), {25'd0, seg}, {25'd0, vecs[v].seg});
         check($sformatf("vec%0d_dp", v), {31'd0, dp}, 32'h1);
      end

      // Input filter: alternating word never reaches shown
      blank_lz = 1'b0;
      data     = 32'h7;
      repeat (4) @(negedge clk);
      check("filt_pre", dut.shown, 32'h7);
      for (int c = 0; c < 20; c++) begin
         data = (c % 2 == 0) ? 32'h1 : 32'h2;
         @(negedge clk);
         check("filt_hold", dut.shown, 32'h7);
      end
      data = 32'h3;
      @(negedge clk);
      check("filt_edge1", dut.shown, 32'h7);
      @(negedge clk);
      check("filt_edge2", dut.shown, 32'h3);
      goto_pos(0, 1);
      check("filt_seg", {25'd0, seg}, 32'h30);

      // Halt marker on dp of digit 0
      goto_pos(0, 0);
      halt = 1'b1;
      @(negedge clk);
      check("halt_e1", {31'd0, dp}, 32'h1);
      @(negedge clk);
      check("halt_e2", {31'd0, dp}, 32'h1);
      @(negedge clk);
      check("halt_e3", {31'd0, dp}, 32'h0);
      goto_pos(3, 1);
      check("halt_dp_d3", {31'd0, dp}, 32'h1);
      goto_pos(0, 1);
      check("halt_dp_d0", {31'd0, dp}, 32'h0);
`ifdef SEG_HALT_BLINK_EN
      cnt_off = 0;
      for (int c = 0; c < 32; c++) begin
         @(negedge clk);
         if (an == 8'hFF) cnt_off++;
      end
      check("blink_off_cnt", cnt_off, 16);
`endif
      halt = 1'b0;
      repeat (6) @(negedge clk);
      cnt_off = 0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         if (an == 8'hFF) cnt_off++;
      end
      check("unhalt_scan", cnt_off, 0);
      goto_pos(0, 1);
      check("unhalt_dp", {31'd0, dp}, 32'h1);

      // Reset mid-scan
      data = 32'h12345678;
      repeat (4) @(negedge clk);
      goto_pos(5, 1);
      check("pre_mid_an", {24'd0, an}, 32'hDF);
      CLR = 1'b1;
      #1;
      check("mid_rst_an", {24'd0, an}, 32'hFF);
      check("mid_rst_seg", {25'd0, seg}, 32'h7F);
      check("mid_rst_dp", {31'd0, dp}, 32'h1);
      @(negedge clk);
      CLR = 1'b0;
      @(negedge clk);
      check("resume_an", {24'd0, an}, 32'hFE);
      goto_pos(1, 0);
      check("resume_an1", {24'd0, an}, 32'hFD);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
